// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: sequencer state encoding and C-instruction bit positions.
package hack_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam int C_BIT  = 15;
    localparam int J1_BIT = 2;
    localparam int J2_BIT = 1;
    localparam int J3_BIT = 0;

endpackage

// File: rtl/jump_cond.sv
// Combinational Hack jump-condition decoder, shared with the CPU decode path.
module jump_cond
    import hack_pkg::*;
(
    input  logic [15:0] instr,
    input  logic        zr,
    input  logic        ng,
    output logic        jump
);

    // Only the C flag and the three jump bits matter here; the rest is ALU/dest encoding.
    logic unused_bits;
    assign unused_bits = ^instr[14:3];

    assign jump = instr[C_BIT] & ((instr[J1_BIT] & ng) |
                                  (instr[J2_BIT] & zr) |
                                  (instr[J3_BIT] & ~ng & ~zr));

endmodule

// File: rtl/hack_pc_ctrl.sv
// Fetch/execute sequencer driving the Hack program counter's reset, load and inc controls.
module hack_pc_ctrl
    import hack_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             rom_req_o,
    input  logic             rom_valid_i,
    input  logic [15:0]      instr_i,
    input  logic             halt_i,
    input  logic             stall_i,
    input  logic             zr_i,
    input  logic             ng_i,
    output logic [15:0]      ir_o,
    output logic             exec_o,
    output logic             pc_reset_o,
    output logic             pc_load_o,
    output logic             pc_inc_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic [BW-1:0] boot_cnt;
    logic          boot_done;
    logic          jump;
    logic          accept;
    logic          retire;

    jump_cond u_jump_cond (
        .instr (ir_o),
        .zr    (zr_i),
        .ng    (ng_i),
        .jump  (jump)
    );

    assign boot_done = (boot_cnt == BOOT_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            BOOT:    if (boot_done) next_state = FETCH;
            FETCH:   if (accept)    next_state = EXEC;
            EXEC:    if (!stall_i)  next_state = FETCH;
            default: next_state = BOOT;
        endcase
    end

    // Everything is qualified by !reset_i so a reset cycle never fetches, retires or moves the PC.
    always_comb begin
        rom_req_o  = 1'b0;
        exec_o     = 1'b0;
        pc_load_o  = 1'b0;
        pc_inc_o   = 1'b0;
        accept     = 1'b0;
        retire     = 1'b0;
        pc_reset_o = reset_i | (state == BOOT);
        if (!reset_i) begin
            unique case (state)
                FETCH: begin
                    rom_req_o = !halt_i;
                    accept    = !halt_i & rom_valid_i;
                end
                EXEC: begin
                    exec_o = 1'b1;
                    if (!stall_i) begin
                        pc_load_o = jump;
                        pc_inc_o  = !jump;
                        retire    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cleared whenever we are outside BOOT so a later reset starts the count afresh.
    always_ff @(posedge clk_i) begin
        if (reset_i || state != BOOT || boot_done) begin
            boot_cnt <= '0;
        end else begin
            boot_cnt <= boot_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ir_o <= '0;
        end else if (accept) begin
            ir_o <= instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            retired_o <= '0;
        end else if (retire) begin
            retired_o <= retired_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hack_pc_ctrl.sv
// Directed bench for hack_pc_ctrl: boot timing, jump decode table, wait/stall/halt, reset and counter wrap.
module tb_hack_pc_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        rom_valid_i;
    logic [15:0] instr_i;
    logic        halt_i;
    logic        stall_i;
    logic        zr_i;
    logic        ng_i;

    logic        rom_req_o;
    logic [15:0] ir_o;
    logic        exec_o;
    logic        pc_reset_o;
    logic        pc_load_o;
    logic        pc_inc_o;
    logic [15:0] retired_o;

    logic        w3_rom_req;
    logic [15:0] w3_ir;
    logic        w3_exec;
    logic        w3_pc_reset;
    logic        w3_pc_load;
    logic        w3_pc_inc;
    logic [2:0]  w3_retired;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_retired = 0;

    typedef struct {
        logic [15:0] instr;
        logic        zr;
        logic        ng;
        logic        exp_load;
        logic        exp_inc;
    } vec_t;

    vec_t vecs[12];

    always #5 clk_i = ~clk_i;

    hack_pc_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rom_req_o   (rom_req_o),
        .rom_valid_i (rom_valid_i),
        .instr_i     (instr_i),
        .halt_i      (halt_i),
        .stall_i     (stall_i),
        .zr_i        (zr_i),
        .ng_i        (ng_i),
        .ir_o        (ir_o),
        .exec_o      (exec_o),
        .pc_reset_o  (pc_reset_o),
        .pc_load_o   (pc_load_o),
        .pc_inc_o    (pc_inc_o),
        .retired_o   (retired_o)
    );

    // Narrow counter copy so the wrap to zero is reachable in a short run.
    hack_pc_ctrl #(.BOOT_CYCLES(2), .CNT_W(3)) dut_w3 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .rom_req_o   (w3_rom_req),
        .rom_valid_i (rom_valid_i),
        .instr_i     (instr_i),
        .halt_i      (halt_i),
        .stall_i     (stall_i),
        .zr_i        (zr_i),
        .ng_i        (ng_i),
        .ir_o        (w3_ir),
        .exec_o      (w3_exec),
        .pc_reset_o  (w3_pc_reset),
        .pc_load_o   (w3_pc_load),
        .pc_inc_o    (w3_pc_inc),
        .retired_o   (w3_retired)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
        end
    endtask

    // One clock cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
    task automatic applyStimulus(input logic rst, input logic valid, input logic [15:0] instr,
                                 input logic halt, input logic stall, input logic zr, input logic ng);
        @(posedge clk_i);
        #1;
        reset_i     = rst;
        rom_valid_i = valid;
        instr_i     = instr;
        halt_i      = halt;
        stall_i     = stall;
        zr_i        = zr;
        ng_i        = ng;
        @(negedge clk_i);
    endtask

    task automatic checkRetired(input string name);
        checkOutput({name, "_retired"}, retired_o, 16'(exp_retired));
        checkOutput({name, "_retired_w3"}, {13'd0, w3_retired}, 16'(exp_retired % 8));
    endtask

    initial begin
        vecs[0]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{16'h0007, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'hE302, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'hE302, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'hEA87, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'hEA87, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'hEA88, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'hE301, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'hE301, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'hE304, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{16'hE305, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'hE306, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_i = 1'b1; rom_valid_i = 1'b0; instr_i = '0;
        halt_i = 1'b0; stall_i = 1'b0; zr_i = 1'b0; ng_i = 1'b0;

        // Reset, with ROM data offered to confirm nothing is requested or latched.
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'h1234, 0, 0, 0, 0);
        checkOutput("rst_pc_reset", pc_reset_o, 1);
        checkOutput("rst_rom_req", rom_req_o, 0);
        checkOutput("rst_exec", exec_o, 0);
        checkOutput("rst_pc_load", pc_load_o, 0);
        checkOutput("rst_pc_inc", pc_inc_o, 0);
        checkOutput("rst_ir", ir_o, 16'h0000);
        checkRetired("rst");

        // Boot: two cycles of PC reset, request in the third.
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("boot1_pc_reset", pc_reset_o, 1);
        checkOutput("boot1_rom_req", rom_req_o, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("boot2_pc_reset", pc_reset_o, 1);
        checkOutput("boot2_rom_req", rom_req_o, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("boot3_pc_reset", pc_reset_o, 0);
        checkOutput("boot3_rom_req", rom_req_o, 1);
        checkOutput("boot3_exec", exec_o, 0);

        // Two-cycle instructions, valid in the same cycle as the request.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1, vecs[i].instr, 0, 0, 0, 0);
            checkOutput($sformatf("v%0d_fetch_req", i), rom_req_o, 1);
            checkOutput($sformatf("v%0d_fetch_exec", i), exec_o, 0);
            checkOutput($sformatf("v%0d_fetch_pc", i), {14'd0, pc_load_o, pc_inc_o}, 16'd0);
            checkRetired($sformatf("v%0d_fetch", i));
            applyStimulus(0, 0, 16'h0000, 0, 0, vecs[i].zr, vecs[i].ng);
            checkOutput($sformatf("v%0d_exec", i), exec_o, 1);
            checkOutput($sformatf("v%0d_ir", i), ir_o, vecs[i].instr);
            checkOutput($sformatf("v%0d_load", i), pc_load_o, vecs[i].exp_load);
            checkOutput($sformatf("v%0d_inc", i), pc_inc_o, vecs[i].exp_inc);
            exp_retired++;
        end

        // ROM waits three cycles, halt then drops the request for one cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
            checkOutput($sformatf("wait%0d_req", i), rom_req_o, 1);
            checkOutput($sformatf("wait%0d_exec", i), exec_o, 0);
        end
        checkRetired("wait");
        applyStimulus(0, 1, 16'hE302, 1, 0, 0, 0);
        checkOutput("halt_req", rom_req_o, 0);
        checkOutput("halt_exec", exec_o, 0);
        applyStimulus(0, 1, 16'hE302, 0, 0, 0, 0);
        checkOutput("halt_off_req", rom_req_o, 1);
        checkOutput("halt_off_exec", exec_o, 0);

        // Two stall cycles with a taken-looking flag, then retire as a plain increment.
        applyStimulus(0, 0, 16'h0000, 0, 1, 1, 0);
        checkOutput("stall1_exec", exec_o, 1);
        checkOutput("stall1_pc", {14'd0, pc_load_o, pc_inc_o}, 16'd0);
        applyStimulus(0, 0, 16'h0000, 0, 1, 1, 0);
        checkOutput("stall2_exec", exec_o, 1);
        checkOutput("stall2_pc", {14'd0, pc_load_o, pc_inc_o}, 16'd0);
        checkRetired("stall2");
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("stall3_exec", exec_o, 1);
        checkOutput("stall3_load", pc_load_o, 0);
        checkOutput("stall3_inc", pc_inc_o, 1);
        exp_retired++;
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("post_stall_exec", exec_o, 0);
        checkRetired("post_stall");

        // Reset arriving in EXEC with an unconditional jump pending.
        applyStimulus(0, 1, 16'hEA87, 0, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("rexec_load", pc_load_o, 0);
        checkOutput("rexec_inc", pc_inc_o, 0);
        checkOutput("rexec_exec", exec_o, 0);
        checkOutput("rexec_pc_reset", pc_reset_o, 1);
        exp_retired = 0;
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkRetired("rexec");
        checkOutput("rexec_ir", ir_o, 16'h0000);
        checkOutput("rexec_boot_pc_reset", pc_reset_o, 1);
        checkOutput("rexec_boot_req", rom_req_o, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("reboot2_pc_reset", pc_reset_o, 1);
        applyStimulus(0, 1, 16'h0010, 0, 0, 0, 0);
        checkOutput("reboot3_pc_reset", pc_reset_o, 0);
        checkOutput("reboot3_req", rom_req_o, 1);
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkOutput("reboot_exec", exec_o, 1);
        checkOutput("reboot_inc", pc_inc_o, 1);
        exp_retired++;
        applyStimulus(0, 0, 16'h0000, 0, 0, 0, 0);
        checkRetired("reboot");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_pc_ctrl.md
# hack_pc_ctrl

Multi-cycle fetch/execute sequencer that drives the load, inc and reset controls of the 16-bit program counter in the Hack CPU. It holds the PC in reset during boot and fetches each instruction from instruction ROM over a request/valid handshake. It latches the instruction, then resolves the C-instruction jump condition from the ALU flags and issues exactly one PC update per retired instruction. It sits between the ROM port, the ALU flag outputs and the PC.

## Interface
- BOOT_CYCLES, 2: cycles the PC is held in reset after `reset_i` deasserts; must be ≥1.
- CNT_W, 16: width of the retired-instruction counter.

- clk_i  in  1  single clock, all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- rom_req_o  out  1  instruction fetch request.
- rom_valid_i  in  1  ROM data valid. Ignored while `rom_req_o`=0.
- instr_i  in  16  ROM data, sampled when `rom_req_o`&`rom_valid_i`.
- halt_i  in  1  blocks the start of the next fetch.
- stall_i  in  1  extends the execute cycle, e.g. for a data-memory wait.
- zr_i  in  1  ALU zero flag for the instruction in EXEC.
- ng_i  in  1  ALU negative flag for the instruction in EXEC.
- ir_o  out  16  latched current instruction.
- exec_o  out  1  the instruction in `ir_o` is executing this cycle.
- pc_reset_o  out  1  to the PC reset input.
- pc_load_o  out  1  to the PC load input; PC takes the A-register value.
- pc_inc_o  out  1  to the PC inc input.
- retired_o  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: BOOT, FETCH, EXEC.
- Reset: state=BOOT, boot counter=0, `ir_o`=0, `retired_o`=0.
- Output reset values: `pc_reset_o`=1; `rom_req_o`, `exec_o`, `pc_load_o` and `pc_inc_o` are all 0.
- `pc_reset_o` = `reset_i` | (state==BOOT).
- BOOT: counter increments each cycle. When it reaches BOOT_CYCLES-1, go to FETCH.
- FETCH:
  - `rom_req_o` = !`halt_i`.
  - When `rom_req_o`&`rom_valid_i`: `ir_o` <= `instr_i`, go to EXEC.
  - `halt_i` asserted in a cycle where valid would arrive: the data is not accepted and the ROM holds its response.
- EXEC:
  - `exec_o`=1.
  - jump = `ir_o`[15] & ((j1&`ng_i`) | (j2&`zr_i`) | (j3&!`ng_i`&!`zr_i`)), with j1/j2/j3 = `ir_o`[2]/[1]/[0].
  - A-instructions (`ir_o`[15]=0) never jump. Code 111 always jumps.
  - `stall_i`=1: `pc_load_o`=`pc_inc_o`=0, stay in EXEC. Flags are re-evaluated each cycle.
  - `stall_i`=0: `pc_load_o`=jump, `pc_inc_o`=!jump, `retired_o`++, go to FETCH.
- `pc_load_o` and `pc_inc_o` are mutually exclusive. They are never asserted outside EXEC or while `pc_reset_o`=1.
- `reset_i` in any state overrides everything: next state BOOT, no retire, no PC load/inc that cycle.

## Timing
- Latency from `reset_i` low to first `rom_req_o`: BOOT_CYCLES cycles.
- Minimum 2 cycles per instruction: FETCH with same-cycle valid, then EXEC without stall.
- Each ROM wait cycle and each stall cycle adds one cycle.
- PC control outputs are combinational from state, `ir_o`, flags and `stall_i`. The PC register updates at the clock edge ending the EXEC cycle.
- `ir_o` is stable from the cycle after acceptance until the next acceptance.
- `retired_o` updates at the same edge as the PC. From all-ones it wraps to 0.

## Structure
- Shared package `hack_pkg`:
  - state enum {BOOT, FETCH, EXEC};
  - constants for the C-instruction flag bit (15) and jump bit indices (2,1,0).
- Sub-module `jump_cond`: combinational; inputs instr[15:0], zr, ng; output jump. It is reusable by the CPU decode path.
- Top level contains the FSM, boot counter, IR register and retire counter.

## Test plan
- Reset then release, BOOT_CYCLES=2 → `pc_reset_o`=1 during reset and 2 cycles after; `rom_req_o` rises in cycle 3.
- A-instruction 0x0010, immediate valid, no stall → EXEC with `pc_inc_o`=1, `pc_load_o`=0; `retired_o` 0→1; 2 cycles total.
- C-instruction 0xE302 (JEQ) with `zr_i`=1 → `pc_load_o`=1. Same instruction with `zr_i`=0, `ng_i`=1 → `pc_inc_o`=1.
- 0xEA87 (0;JMP) with any flags → `pc_load_o`=1. 0xEA88 (no jump) → `pc_inc_o`=1.
- `rom_valid_i` delayed 3 cycles, then `stall_i` high 2 cycles in EXEC → 3 wait cycles with req held; `exec_o` high for 3 cycles; single inc only in the last; `halt_i` in FETCH drops `rom_req_o`.
- `reset_i` pulsed during EXEC with a pending jump → no load/inc that cycle; `retired_o`=0; BOOT re-entered. Preload `retired_o`=0xFFFF and retire one → 0x0000.
